// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, requester IDs, arbitration modes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_t;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Two-way request picker: fixed LS-first or round-robin against the last grant.
// Purely combinational; a lone requester always wins.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic    if_req,
    input  logic    ls_req,
    input  req_id_t last_grant,
    input  logic    mode,
    output logic    valid,
    output req_id_t winner
);

    always_comb begin
        valid  = if_req | ls_req;
        winner = REQ_IF;
        if (ls_req)
            winner = REQ_LS;
        // On a tie in round-robin mode, whoever did not win last time goes first.
        if (mode == ARB_RR && if_req && ls_req) begin
            if (last_grant == REQ_LS)
                winner = REQ_IF;
            else
                winner = REQ_LS;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IF and LS: gnt/mem_req one cycle after arbitration, rvalid one cycle after ack/timeout.
// Requesters hold req until gnt; losers wait through BUSY/RESP with no queueing or preemption.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter  int ADDR_WIDTH     = 32,
    parameter  int DATA_WIDTH     = 32,
    parameter  int ARB_MODE       = 1,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int BE_W           = DATA_WIDTH / 8
) (
    input  logic                  mem_arbiter_clock_in,
    input  logic                  mem_arbiter_reset_in,
    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_gnt_out,
    output logic                  if_rvalid_out,
    output logic [DATA_WIDTH-1:0] if_rdata_out,
    output logic                  if_err_out,
    input  logic                  ls_req_in,
    input  logic                  ls_we_in,
    input  logic [BE_W-1:0]       ls_be_in,
    input  logic [ADDR_WIDTH-1:0] ls_addr_in,
    input  logic [DATA_WIDTH-1:0] ls_wdata_in,
    output logic                  ls_gnt_out,
    output logic                  ls_rvalid_out,
    output logic [DATA_WIDTH-1:0] ls_rdata_out,
    output logic                  ls_err_out,
    output logic                  mem_req_out,
    output logic                  mem_we_out,
    output logic [BE_W-1:0]       mem_be_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [DATA_WIDTH-1:0] mem_wdata_out,
    input  logic                  mem_ack_in,
    input  logic [DATA_WIDTH-1:0] mem_rdata_in
);

    localparam logic       PICK_MODE = (ARB_MODE != 0) ? ARB_RR : ARB_FIXED;
    // Counter value seen in the last BUSY cycle before giving up.
    localparam logic [7:0] TO_LAST   = 8'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    req_id_t         owner_q, last_grant_q, winner;
    logic            pick_vld;
    logic [7:0]      cnt_q;
    logic            timeout_hit;

    mem_arbiter_pick u_pick (
        .if_req     (if_req_in),
        .ls_req     (ls_req_in),
        .last_grant (last_grant_q),
        .mode       (PICK_MODE),
        .valid      (pick_vld),
        .winner     (winner)
    );

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge mem_arbiter_clock_in or posedge mem_arbiter_reset_in) begin
        if (mem_arbiter_reset_in)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_vld) state_d = ST_BUSY;
            ST_BUSY: if (mem_ack_in || timeout_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mem_arbiter_clock_in or posedge mem_arbiter_reset_in) begin
        if (mem_arbiter_reset_in) begin
            owner_q       <= REQ_IF;
            last_grant_q  <= REQ_LS;
            cnt_q         <= '0;
            if_gnt_out    <= 1'b0;
            ls_gnt_out    <= 1'b0;
            if_rvalid_out <= 1'b0;
            ls_rvalid_out <= 1'b0;
            if_rdata_out  <= '0;
            ls_rdata_out  <= '0;
            if_err_out    <= 1'b0;
            ls_err_out    <= 1'b0;
            mem_req_out   <= 1'b0;
            mem_we_out    <= 1'b0;
            mem_be_out    <= '0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
        end else begin
            if_gnt_out    <= 1'b0;
            ls_gnt_out    <= 1'b0;
            if_rvalid_out <= 1'b0;
            ls_rvalid_out <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        owner_q      <= winner;
                        last_grant_q <= winner;
                        cnt_q        <= '0;
                        mem_req_out  <= 1'b1;
                        if (winner == REQ_LS) begin
                            ls_gnt_out    <= 1'b1;
                            mem_we_out    <= ls_we_in;
                            mem_be_out    <= ls_be_in;
                            mem_addr_out  <= ls_addr_in;
                            mem_wdata_out <= ls_wdata_in;
                        end else begin
                            if_gnt_out    <= 1'b1;
                            mem_we_out    <= 1'b0;
                            mem_be_out    <= '1;
                            mem_addr_out  <= if_addr_in;
                            mem_wdata_out <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q + 8'd1;
                    // Ack wins over a timeout landing in the same cycle.
                    if (mem_ack_in || timeout_hit) begin
                        mem_req_out <= 1'b0;
                        if (owner_q == REQ_LS) begin
                            ls_rvalid_out <= 1'b1;
                            ls_err_out    <= !mem_ack_in;
                            ls_rdata_out  <= (mem_ack_in && !mem_we_out) ? mem_rdata_in : '0;
                        end else begin
                            if_rvalid_out <= 1'b1;
                            if_err_out    <= !mem_ack_in;
                            if_rdata_out  <= mem_ack_in ? mem_rdata_in : '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (RR/TO=4, fixed/TO=4, RR/no timeout), one active at a time.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst [NI];
    logic          if_req, ls_req, ls_we, mem_ack;
    logic [AW-1:0] if_addr, ls_addr;
    logic [BW-1:0] ls_be;
    logic [DW-1:0] ls_wdata, mem_rdata;

    logic          if_gnt [NI], if_rvalid [NI], if_err [NI];
    logic          ls_gnt [NI], ls_rvalid [NI], ls_err [NI];
    logic          m_req [NI], m_we [NI];
    logic [DW-1:0] if_rdata [NI], ls_rdata [NI], m_wdata [NI];
    logic [AW-1:0] m_addr [NI];
    logic [BW-1:0] m_be [NI];

    int sel = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_arbiter #(
            .ADDR_WIDTH     (AW),
            .DATA_WIDTH     (DW),
            .ARB_MODE       ((g == 1) ? 0 : 1),
            .TIMEOUT_CYCLES ((g == 2) ? 0 : 4)
        ) u_dut (
            .mem_arbiter_clock_in (clk),
            .mem_arbiter_reset_in (rst[g]),
            .if_req_in            (if_req),
            .if_addr_in           (if_addr),
            .if_gnt_out           (if_gnt[g]),
            .if_rvalid_out        (if_rvalid[g]),
            .if_rdata_out         (if_rdata[g]),
            .if_err_out           (if_err[g]),
            .ls_req_in            (ls_req),
            .ls_we_in             (ls_we),
            .ls_be_in             (ls_be),
            .ls_addr_in           (ls_addr),
            .ls_wdata_in          (ls_wdata),
            .ls_gnt_out           (ls_gnt[g]),
            .ls_rvalid_out        (ls_rvalid[g]),
            .ls_rdata_out         (ls_rdata[g]),
            .ls_err_out           (ls_err[g]),
            .mem_req_out          (m_req[g]),
            .mem_we_out           (m_we[g]),
            .mem_be_out           (m_be[g]),
            .mem_addr_out         (m_addr[g]),
            .mem_wdata_out        (m_wdata[g]),
            .mem_ack_in           (mem_ack),
            .mem_rdata_in         (mem_rdata)
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input int s);
        for (int i = 0; i < NI; i++) rst[i] = 1'b1;
        if_req = 1'b0; ls_req = 1'b0; mem_ack = 1'b0;
        #1;
        rst[s] = 1'b0;
        sel    = s;
        step();
    endtask

    // Waits (bounded) for a grant, checks the winner, acks at once and checks the owner's response.
    task automatic grant_cycle(input string tag, input bit exp_ls);
        int n = 0;
        while (!if_gnt[sel] && !ls_gnt[sel] && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_gnt"}, {if_gnt[sel], ls_gnt[sel]}, exp_ls ? 2'b01 : 2'b10);
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_ack = 1'b0;
        chk({tag, "_rv"}, {if_rvalid[sel], ls_rvalid[sel]}, exp_ls ? 2'b01 : 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int bad;
        for (int i = 0; i < NI; i++) rst[i] = 1'b1;
        if_req = 0; ls_req = 0; ls_we = 0; mem_ack = 0;
        if_addr = '0; ls_addr = '0; ls_be = '0; ls_wdata = '0; mem_rdata = '0;
        step();
        step();
        for (int i = 0; i < NI; i++) begin
            chk("rst_flags", {if_gnt[i], if_rvalid[i], if_err[i], ls_gnt[i], ls_rvalid[i],
                              ls_err[i], m_req[i], m_we[i], m_be[i]}, 0);
            chk("rst_buses", m_addr[i] | m_wdata[i] | if_rdata[i] | ls_rdata[i], 0);
        end

        // Single IF read, ack on the first BUSY cycle.
        select(0);
        if_req = 1; if_addr = 32'h100;
        step();
        chk("t1_gnt", {if_gnt[sel], ls_gnt[sel]}, 2'b10);
        chk("t1_mreq", m_req[sel], 1);
        chk("t1_we", m_we[sel], 0);
        chk("t1_be", m_be[sel], 4'hF);
        chk("t1_addr", m_addr[sel], 32'h100);
        if_req = 0; mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 0;
        chk("t1_rv", {if_rvalid[sel], ls_rvalid[sel]}, 2'b10);
        chk("t1_rdata", if_rdata[sel], 32'hDEAD_BEEF);
        chk("t1_err", if_err[sel], 0);
        chk("t1_off", {m_req[sel], if_gnt[sel]}, 0);
        step();
        chk("t1_idle", {m_req[sel], if_rvalid[sel]}, 0);

        // LS write, ack on the 4th BUSY cycle (coincides with timeout: ack wins).
        ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h200; ls_wdata = 32'h1234;
        step();
        chk("t2_gnt", {if_gnt[sel], ls_gnt[sel]}, 2'b01);
        chk("t2_mem", {m_we[sel], m_be[sel], m_addr[sel], m_wdata[sel]}, {1'b1, 4'b0011, 32'h200, 32'h1234});
        ls_req = 0; mem_rdata = 32'hFFFF_FFFF;
        hi = 0;
        for (int k = 1; k <= 4; k++) begin
            if (m_req[sel]) hi++;
            if (k == 4) mem_ack = 1;
            step();
        end
        mem_ack = 0;
        chk("t2_reqcyc", hi, 4);
        chk("t2_rv", {if_rvalid[sel], ls_rvalid[sel], m_req[sel]}, 3'b010);
        chk("t2_rdata", ls_rdata[sel], 0);
        chk("t2_err", ls_err[sel], 0);
        step();

        // IF read with no ack: timeout after 4 BUSY cycles.
        if_req = 1; if_addr = 32'h180;
        step();
        chk("t3_gnt", {if_gnt[sel], ls_gnt[sel]}, 2'b10);
        if_req = 0; mem_rdata = 32'hCAFE_F00D;
        hi = 0;
        for (int k = 1; k <= 4; k++) begin
            if (m_req[sel]) hi++;
            step();
        end
        chk("t3_reqcyc", hi, 4);
        chk("t3_rv", {if_rvalid[sel], ls_rvalid[sel], m_req[sel]}, 3'b100);
        chk("t3_err", if_err[sel], 1);
        chk("t3_rdata", if_rdata[sel], 0);
        step();

        // Round-robin with both held; fresh reset so last_grant = LS.
        select(0);
        if_req = 1; if_addr = 32'h10; ls_req = 1; ls_we = 0; ls_addr = 32'h20; ls_be = 4'hF;
        grant_cycle("rr0", 0);
        grant_cycle("rr1", 1);
        grant_cycle("rr2", 0);
        grant_cycle("rr3", 1);
        if_req = 0; ls_req = 0;
        step();

        // Fixed priority with both held: LS every time.
        select(1);
        if_req = 1; ls_req = 1;
        grant_cycle("fx0", 1);
        grant_cycle("fx1", 1);
        grant_cycle("fx2", 1);
        if_req = 0; ls_req = 0;
        step();

        // Reset mid-BUSY, then a clean access.
        select(0);
        if_req = 1; if_addr = 32'h240;
        step();
        chk("t5_gnt_pre", {if_gnt[sel], m_req[sel]}, 2'b11);
        if_req = 0;
        #2;
        rst[0] = 1;
        #1;
        chk("t5_rst_now", {m_req[sel], if_gnt[sel], ls_gnt[sel], if_rvalid[sel], ls_rvalid[sel]}, 0);
        #1;
        rst[0] = 0;
        mem_ack = 1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (if_rvalid[sel] || ls_rvalid[sel] || m_req[sel]) bad++;
        end
        mem_ack = 0;
        chk("t5_stale", bad, 0);
        ls_req = 1; ls_we = 0; ls_addr = 32'h300; ls_be = 4'hF;
        step();
        chk("t5_gnt", {if_gnt[sel], ls_gnt[sel]}, 2'b01);
        ls_req = 0; mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 0;
        chk("t5_rv", {if_rvalid[sel], ls_rvalid[sel]}, 2'b01);
        chk("t5_rdata", ls_rdata[sel], 32'h0BAD_F00D);
        step();

        // Timeout disabled: 300-cycle ack delay.
        select(2);
        if_req = 1; if_addr = 32'h400;
        step();
        chk("t6_gnt", {if_gnt[sel], ls_gnt[sel]}, 2'b10);
        if_req = 0;
        bad = 0;
        for (int k = 1; k < 300; k++) begin
            if (!m_req[sel] || if_rvalid[sel]) bad++;
            step();
        end
        chk("t6_held", bad, 0);
        mem_ack = 1; mem_rdata = 32'h0000_600D;
        step();
        mem_ack = 0;
        chk("t6_rv", {if_rvalid[sel], ls_rvalid[sel]}, 2'b10);
        chk("t6_err", if_err[sel], 0);
        chk("t6_rdata", if_rdata[sel], 32'h0000_600D);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single memory port of the multicycle core between instruction fetch (IF, read-only) and load/store (LS) requesters. It arbitrates pending requests and registers the winner's address and payload. It then drives a req/ack memory handshake and returns read data with a one-cycle response pulse to the owner. It sits between the control FSM/datapath and the memory model; the control unit stalls its state machine on gnt/rvalid.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; byte-enable width BE_W = DATA_WIDTH/8
ARB_MODE, 1, 0 = fixed priority (LS over IF), 1 = round-robin
TIMEOUT_CYCLES, 64, BUSY cycles without ack before error response; 0 disables; legal range 0..255

Ports:
mem_arbiter_clock_in  in  1  clock, all state on rising edge
mem_arbiter_reset_in  in  1  asynchronous, active-high reset
if_req_in  in  1  IF request; held with if_addr_in until if_gnt_out
if_addr_in  in  ADDR_WIDTH  IF read address
if_gnt_out  out  1  one-cycle pulse: IF request accepted
if_rvalid_out  out  1  one-cycle pulse: IF response valid
if_rdata_out  out  DATA_WIDTH  IF read data, valid with if_rvalid_out
if_err_out  out  1  IF timeout error, valid with if_rvalid_out
ls_req_in  in  1  LS request; held with payload until ls_gnt_out
ls_we_in  in  1  1 = write, 0 = read
ls_be_in  in  BE_W  byte enables
ls_addr_in  in  ADDR_WIDTH  LS address
ls_wdata_in  in  DATA_WIDTH  LS write data
ls_gnt_out  out  1  one-cycle pulse: LS request accepted
ls_rvalid_out  out  1  one-cycle pulse: LS response (read data or write done)
ls_rdata_out  out  DATA_WIDTH  LS read data; 0 for writes
ls_err_out  out  1  LS timeout error, valid with ls_rvalid_out
mem_req_out  out  1  memory request, held until ack or timeout
mem_we_out  out  1  memory write enable
mem_be_out  out  BE_W  memory byte enables
mem_addr_out  out  ADDR_WIDTH  memory address
mem_wdata_out  out  DATA_WIDTH  memory write data
mem_ack_in  in  1  memory completion, sampled while mem_req_out = 1
mem_rdata_in  in  DATA_WIDTH  read data, valid with mem_ack_in

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; timeout counter 0; last_grant = LS. This applies mid-transaction too: mem_req_out drops at once and no rvalid is issued for the aborted access.
- States: IDLE, BUSY, RESP.
- IDLE: if any request is pending, pick a winner.
  - ARB_MODE=0: LS wins whenever ls_req_in = 1.
  - ARB_MODE=1: on a tie, the requester other than last_grant wins; a lone requester always wins.
- IDLE -> BUSY at the edge where a winner exists. At that edge: latch owner, addr, we, be, wdata into mem_* registers; update last_grant; clear counter. IF grants force we = 0 and be = all ones.
- BUSY cycle 1: gnt_out of the owner = 1 (exactly one cycle); mem_req_out = 1 throughout BUSY.
- BUSY: on a rising edge with mem_ack_in = 1, go to RESP. Capture mem_rdata_in (captured value is 0 if we = 1); err = 0.
- BUSY: when the counter reaches TIMEOUT_CYCLES without ack, go to RESP with err = 1 and rdata = 0. Ack in the same cycle as the timeout has priority: err = 0.
- mem_req_out deasserts in RESP.
- RESP: owner's rvalid_out = 1 for one cycle with registered rdata/err; the non-owner's response outputs stay 0. RESP -> IDLE unconditionally.
- Minimum turnaround, with ack on the first BUSY cycle: req at cycle N, gnt and mem_req at N+1, rvalid at N+2, next arbitration at N+3.
- Requests arriving during BUSY/RESP wait; there is no queueing and no preemption. A requester dropping req before gnt is a protocol violation with undefined behaviour.
- rdata_out/err_out hold their last value outside rvalid; benches must only check them when rvalid = 1.

Decomposition:
- Package mem_arbiter_pkg: state encodings (IDLE=2'b00, BUSY=2'b01, RESP=2'b10), requester IDs (REQ_IF=1'b0, REQ_LS=1'b1), ARB_MODE constants (ARB_FIXED=0, ARB_RR=1).
- One sub-module, mem_arbiter_pick: combinational two-way picker with inputs (if_req, ls_req, last_grant, mode) and outputs (valid, winner).

Test Plan:
- Single IF read at 0x100, ack on the first BUSY cycle with rdata 0xDEADBEEF -> if_gnt pulse at N+1, if_rvalid at N+2 with 0xDEADBEEF and err 0, mem_we 0, mem_be 4'hF.
- LS write to 0x200, be 4'b0011, wdata 0x1234, ack after 3 cycles -> mem_req high 4 cycles with we 1, be 4'b0011, wdata 0x1234; ls_rvalid with rdata 0.
- IF and LS held continuously, ARB_MODE=1 -> grant order IF, LS, IF, LS; with ARB_MODE=0 -> LS every time.
- TIMEOUT_CYCLES=4, no ack -> mem_req high exactly 4 cycles, then owner rvalid with err 1 and rdata 0; ack arriving on the 4th cycle instead -> err 0.
- Reset asserted in BUSY -> mem_req_out and all gnt/rvalid go 0 immediately; after release, the next access is granted normally with no stale response.
- TIMEOUT_CYCLES=0 with 300-cycle ack delay -> no error; rvalid is issued after the ack.
